pulse_width_gen: RTL and testbench

- Programmable strobe generator: the driving end of the start-pulse width measurement checker.
- Accepts a length command over a valid/ready handshake.
- Drives `start` high for exactly that many consecutive posedges of `clk`, then low for a guaranteed gap, then signals completion.
- Sits in front of any block or assertion that measures start-high duration, so pulse width is deterministic rather than random.

---
 rtl/pulse_width_gen.sv | 109 ++++++++++
 tb/tb_pulse_width_gen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_width_gen.sv
// rtl/pulse_width_gen.sv - programmable start strobe: exact high width, guaranteed low gap, done/abort status
module pulse_width_gen #(
  parameter int CNT_W   = 8,
  parameter int MIN_GAP = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [CNT_W-1:0] i_cmd_len,
  input  logic             i_abort,
  output logic             o_start,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_aborted,
  output logic             o_err_zero,
  output logic [CNT_W-1:0] o_pulse_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [3:0] GAP_LAST   = 4'(MIN_GAP - 1);
  localparam bit         GAP_BYPASS = (MIN_GAP == 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_pulse_cnt;
  logic [3:0]       r_gap_cnt;
  logic             r_start;
  logic             r_done;
  logic             r_aborted;
  logic             r_err_zero;

  logic             w_accept;
  logic [CNT_W-1:0] w_len_m1;
  logic             w_last_edge;

  assign w_accept    = i_cmd_valid && (r_state == S_IDLE);
  assign w_len_m1    = r_len - CNT_W'(1);
  // Compare against len-1 so len = 2^CNT_W-1 never needs a wider counter.
  assign w_last_edge = (r_pulse_cnt == w_len_m1);

  // IDLE is entered at the edge before the final gap edge, so a command
  // accepted in the done cycle still leaves exactly MIN_GAP low edges.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_pulse_cnt <= '0;
      r_gap_cnt   <= '0;
      r_start     <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_err_zero  <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_err_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (i_cmd_len == '0) begin
              r_err_zero <= 1'b1;
            end else begin
              r_len       <= i_cmd_len;
              r_pulse_cnt <= '0;
              r_aborted   <= 1'b0;
              r_start     <= 1'b1;
              r_state     <= S_HIGH;
            end
          end
        end
        S_HIGH: begin
          r_pulse_cnt <= r_pulse_cnt + CNT_W'(1);
          if (w_last_edge || i_abort) begin
            r_start   <= 1'b0;
            r_aborted <= !w_last_edge;
            r_gap_cnt <= 4'd1;
            if (GAP_BYPASS) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cmd_ready = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_start     = r_start;
  assign o_done      = r_done;
  assign o_aborted   = r_aborted;
  assign o_err_zero  = r_err_zero;
  assign o_pulse_cnt = r_pulse_cnt;

endmodule

// File: tb/tb_pulse_width_gen.sv
// tb/tb_pulse_width_gen.sv - directed self-checking bench for pulse_width_gen
module tb_pulse_width_gen;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_len;
  logic             abort;
  logic             start;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             err_zero;
  logic [CNT_W-1:0] pulse_cnt;

  int total = 0;
  int bad   = 0;

  pulse_width_gen #(.CNT_W(CNT_W), .MIN_GAP(1)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_len   (cmd_len),
    .i_abort     (abort),
    .o_start     (start),
    .o_busy      (busy),
    .o_done      (done),
    .o_aborted   (aborted),
    .o_err_zero  (err_zero),
    .o_pulse_cnt (pulse_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a command at the next edge, then drop valid.
  task automatic issue(input logic [CNT_W-1:0] len);
    cmd_valid = 1'b1;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
    cmd_len   = 8'd99;
  endtask

  // Count edges at which start is sampled high until it drops (bounded).
  task automatic run_pulse(input int limit, output int highs);
    highs = 0;
    for (int i = 0; i < limit && start; i++) begin
      tick();
      highs++;
    end
  endtask

  int          highs;
  int          dones;
  logic [8:0]  pat;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; abort = 1'b0;
    tick(); tick();
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_zero, 0);
    chk("rst_cnt", pulse_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("rst_ready", cmd_ready, 1);

    // len=12
    issue(8'd12);
    chk("l12_start_rise", start, 1);
    chk("l12_busy", busy, 1);
    chk("l12_ready", cmd_ready, 0);
    run_pulse(300, highs);
    chk("l12_highs", highs, 12);
    chk("l12_cnt", pulse_cnt, 12);
    chk("l12_done", done, 1);
    chk("l12_aborted", aborted, 0);
    tick();
    chk("l12_done_clr", done, 0);
    chk("l12_idle", busy, 0);

    // zero length dropped
    issue(8'd0);
    chk("z_err", err_zero, 1);
    chk("z_start", start, 0);
    chk("z_busy", busy, 0);
    chk("z_ready", cmd_ready, 1);
    chk("z_cnt_hold", pulse_cnt, 12);
    tick();
    chk("z_err_clr", err_zero, 0);

    // maximum length
    issue(8'd255);
    run_pulse(300, highs);
    chk("l255_highs", highs, 255);
    chk("l255_cnt", pulse_cnt, 255);
    chk("l255_done", done, 1);

    tick();
    // back-to-back 3 then 4 with valid held
    cmd_valid = 1'b1; cmd_len = 8'd3;
    tick();
    cmd_len = 8'd4;
    dones = 0;
    pat   = '0;
    for (int i = 0; i < 9; i++) begin
      pat[8-i] = start;
      tick();
      if (done) dones++;
      if (i == 3) cmd_valid = 1'b0;
    end
    chk("b2b_pattern", pat, 9'b111011110);
    chk("b2b_dones", dones, 2);
    chk("b2b_cnt", pulse_cnt, 4);

    // abort on 5th high edge of len=10
    issue(8'd10);
    for (int i = 0; i < 4; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab5_start", start, 0);
    chk("ab5_cnt", pulse_cnt, 5);
    chk("ab5_done", done, 1);
    chk("ab5_aborted", aborted, 1);
    tick();

    // abort on the final edge counts as normal completion
    issue(8'd10);
    for (int i = 0; i < 9; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab10_cnt", pulse_cnt, 10);
    chk("ab10_done", done, 1);
    chk("ab10_aborted", aborted, 0);
    tick();

    // reset in the middle of a len=8 pulse
    issue(8'd8);
    tick(); tick(); tick();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_start", start, 0);
    chk("mr_cnt", pulse_cnt, 0);
    chk("mr_busy", busy, 0);
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || err_zero) dones++;
    end
    chk("mr_no_done", dones, 0);
    chk("mr_ready", cmd_ready, 1);
    issue(8'd2);
    run_pulse(20, highs);
    chk("mr_l2_highs", highs, 2);
    chk("mr_l2_cnt", pulse_cnt, 2);
    chk("mr_l2_done", done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
